// File: rtl/mdu.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Define MDU_FAST_MUL_EN to replace the iterative multiply with a single-cycle product.
module mdu #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned     CntW    = $clog2(XLEN);
  localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);
  localparam logic [XLEN-1:0] MinNeg  = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] OpMul    = 3'd0;
  localparam logic [2:0] OpMulh   = 3'd1;
  localparam logic [2:0] OpMulhsu = 3'd2;
  localparam logic [2:0] OpMulhu  = 3'd3;
  localparam logic [2:0] OpDiv    = 3'd4;
  localparam logic [2:0] OpDivu   = 3'd5;
  localparam logic [2:0] OpRem    = 3'd6;
  localparam logic [2:0] OpRemu   = 3'd7;

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d;    // multiplicand or divisor magnitude
  logic [XLEN-1:0]   hi_q, hi_d;  // product high half or partial remainder
  logic [XLEN-1:0]   lo_q, lo_d;  // multiplier/product low half or dividend/quotient
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic              spec_q, spec_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              s1_neg, s2_neg;
  logic [XLEN-1:0]   abs1, abs2;
  logic [XLEN:0]     mul_sum;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff;
  logic [2*XLEN-1:0] prod;

  assign s1_neg   = src1_i[XLEN-1];
  assign s2_neg   = src2_i[XLEN-1];
  assign abs1     = s1_neg ? -src1_i : src1_i;
  assign abs2     = s2_neg ? -src2_i : src2_i;
  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
  assign div_ge   = {hi_q, lo_q[XLEN-1]} >= {1'b0, a_q};
  // Remainder stays below the divisor, so the modular XLEN-bit difference is exact.
  assign div_diff = {hi_q[XLEN-2:0], lo_q[XLEN-1]} - a_q;
  assign prod     = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};

`ifdef MDU_FAST_MUL_EN
  logic signed [2*XLEN+1:0] fast_a, fast_b, fast_prod;
  assign fast_a    = {{(XLEN+2){((op_q == OpMulh) || (op_q == OpMulhsu)) & a_q[XLEN-1]}}, a_q};
  assign fast_b    = {{(XLEN+2){(op_q == OpMulh) & lo_q[XLEN-1]}}, lo_q};
  assign fast_prod = fast_a * fast_b;
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    spec_d   = spec_q;
    done_d   = 1'b0;
    result_d = result_q;

    unique case (state_q)
      StIdle: begin
        if (start_i && !flush_i) begin
          op_d    = op_i;
          cnt_d   = '0;
          spec_d  = 1'b0;
          hi_d    = '0;
          state_d = StCalc;
          case (op_i)
            OpMul:    begin a_d = src1_i; lo_d = src2_i; neg_d = 1'b0;            end
            OpMulh:   begin a_d = abs1;   lo_d = abs2;   neg_d = s1_neg ^ s2_neg; end
            OpMulhsu: begin a_d = abs1;   lo_d = src2_i; neg_d = s1_neg;          end
            OpMulhu:  begin a_d = src1_i; lo_d = src2_i; neg_d = 1'b0;            end
            OpDiv:    begin a_d = abs2;   lo_d = abs1;   neg_d = s1_neg ^ s2_neg; end
            OpDivu:   begin a_d = src2_i; lo_d = src1_i; neg_d = 1'b0;            end
            OpRem:    begin a_d = abs2;   lo_d = abs1;   neg_d = s1_neg;          end
            default:  begin a_d = src2_i; lo_d = src1_i; neg_d = 1'b0;            end
          endcase
          // Special results are parked in lo_q and emitted unmodified by FIX.
          if (op_i[2] && (src2_i == '0)) begin
            spec_d  = 1'b1;
            lo_d    = op_i[1] ? src1_i : '1;
            state_d = StFix;
          end else if (((op_i == OpDiv) || (op_i == OpRem)) && (src1_i == MinNeg) &&
                       (src2_i == '1)) begin
            spec_d  = 1'b1;
            lo_d    = op_i[1] ? '0 : src1_i;
            state_d = StFix;
          end
`ifdef MDU_FAST_MUL_EN
          if (!op_i[2]) begin
            a_d     = src1_i;
            lo_d    = src2_i;
            neg_d   = 1'b0;
            state_d = StFix;
          end
`endif
        end
      end
      StCalc: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q[2]) begin
          hi_d = div_ge ? div_diff : {hi_q[XLEN-2:0], lo_q[XLEN-1]};
          lo_d = {lo_q[XLEN-2:0], div_ge};
        end else begin
          hi_d = mul_sum[XLEN:1];
          lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        if (cnt_q == CntLast) state_d = StFix;
      end
      StFix: begin
        state_d = StIdle;
        done_d  = 1'b1;
        if (spec_q) begin
          result_d = lo_q;
        end else begin
          case (op_q)
            OpMul:                     result_d = prod[XLEN-1:0];
            OpMulh, OpMulhsu, OpMulhu: result_d = prod[2*XLEN-1:XLEN];
            OpDiv, OpDivu:             result_d = neg_q ? -lo_q : lo_q;
            default:                   result_d = neg_q ? -hi_q : hi_q;
          endcase
`ifdef MDU_FAST_MUL_EN
          if (!op_q[2]) begin
            result_d = (op_q == OpMul) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
          end
`endif
        end
      end
      default: state_d = StIdle;
    endcase

    if (flush_i) begin
      state_d  = StIdle;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      op_q     <= '0;
      a_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      spec_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      spec_q   <= spec_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy_o   = (state_q != StIdle);
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: doc/mdu.md
# mdu

Parametrised multi-cycle multiply/divide unit implementing the RV32M operation set alongside the combinational ALU in the execute stage. It accepts one operation per start pulse, computes iteratively (shift-add multiply, restoring divide) and returns a registered result with a one-cycle done pulse. Pipeline control stalls on `busy` and can squash an in-flight operation with `flush`.

## Interface
- `XLEN`, 32: operand/result width; any even value ≥ 8.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `op`  in  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `src1`  in  XLEN  rs1 operand (multiplicand / dividend), captured at accept.
- `src2`  in  XLEN  rs2 operand (multiplier / divisor), captured at accept.
- `flush`  in  1  abort in-flight operation.
- `busy`  out  1  operation in progress; high from the cycle after accept until the cycle `done` rises.
- `done`  out  1  one-cycle pulse: `result` valid.
- `result`  out  XLEN  registered result; holds until the next `done`.

## Operation
- States: IDLE, CALC, FIX. Reset → IDLE; `busy`=0, `done`=0, `result`=0, iteration counter=0.
- IDLE: on `start`=1 and `flush`=0, latch `op`, `src1`, `src2`.
  - Signed ops (MULH, DIV, REM; src1 only for MULHSU) take absolute values and record result sign.
  - Special cases skip CALC and go straight to result (see below); otherwise → CALC with counter=0.
- CALC: one bit per cycle, counter 0..XLEN-1; multiply accumulates a 2·XLEN product, divide shifts a partial remainder and subtracts the divisor when non-negative. At counter=XLEN-1 → FIX.
- FIX: apply sign correction (two's-complement negate); select low half (MUL), high half (MULH/MULHSU/MULHU), quotient (DIV/DIVU) or remainder (REM/REMU); write `result`, pulse `done`, → IDLE.
- Sign rules: quotient negative iff operand signs differ; remainder takes the dividend's sign; MULHSU treats src2 as unsigned.
- Special cases (result in 1 cycle, no CALC):
  - divisor=0: DIV/DIVU → all ones; REM/REMU → src1.
  - DIV with src1=−2^(XLEN−1), src2=−1: quotient src1, REM 0.
- `start` while `busy`=1: ignored, no side effects.
- `flush`=1 in any state: next state IDLE, `busy`→0, no `done`, `result` unchanged. `flush` and `start` in the same cycle: flush wins, request dropped.
- `rst` mid-operation: as reset, including `result`→0.

## Timing
- Accept edge E0. Normal op: CALC at E1..E_XLEN, FIX writes `result` and raises `done` at E_(XLEN+1); latency XLEN+1 cycles (33 at XLEN=32).
- Special case: `done` after E1; latency 1.
- `busy` falls in the same cycle `done` rises; a new `start` is accepted in that cycle (back-to-back throughput XLEN+1 cycles).
- `done` is exactly one cycle wide.

## Configuration
- `MDU_FAST_MUL_EN` defined: MUL/MULH/MULHSU/MULHU use a single-cycle signed (XLEN+1)×(XLEN+1) product registered in FIX; multiply latency 1, same `busy`/`done` semantics as special cases. Divide unchanged.
- Undefined: all multiplies iterative, latency XLEN+1; no hardware multiplier inferred.

## Test plan
- MUL/MULHU src1=0x3600000E, src2=0x00000100 → `result` 0x00000E00 / 0x00000036, `done` at accept+33 (accept+1 with `MDU_FAST_MUL_EN`).
- MULHSU src1=0xFFFFFFFF, src2=0xFFFFFFFF → 0xFFFFFFFF; MULH same operands → 0x00000000.
- DIV/REM src1=0xFFFFFFF9 (−7), src2=2 → 0xFFFFFFFD / 0xFFFFFFFF; DIVU src1=0x000000EF, src2=0x0000A001 → 0, REMU → 0x000000EF.
- DIVU 5/0 → 0xFFFFFFFF, REMU 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0; each `done` at accept+1.
- DIV started, `flush` at accept+10 → `busy`=0 next cycle, no `done`, `result` keeps prior value; `start` during `busy` ignored; `start`+`flush` same cycle → dropped.
- `rst` at accept+5 → `busy`=0, `done`=0, `result`=0 next cycle; back-to-back MUL then DIVU with `start` in the `done` cycle → both complete correctly.
